// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Power-up / recovery sequencer for the on-chip PLL, clocked by the PLL reference.
//   Holds PLL RESET, waits for LOCK (timeout + bounded retries), requires LOCK to stay
//   high, then enables the output clocks and releases two downstream resets in order.
//   Loss of lock or a force_relock request restarts the whole sequence.
// Ports
//   clkin         reference clock (same net as PLL CLKIN)
//   rst_n         asynchronous active-low reset
//   pll_lock      PLL LOCK, asynchronous (2-FF synchronised to lock_s)
//   force_relock  single-cycle request: restart sequence, clear retries and fail
//   pll_reset     PLL RESET, active high
//   clk_en        PLL ENCLK0/ENCLK1
//   rst0_n        CLKOUT0 domain reset (re-synchronise at destination)
//   rst1_n        CLKOUT1 domain reset (re-synchronise at destination)
//   ready         sequence complete, both domains out of reset
//   fail          retries exhausted; sticky until force_relock or rst_n
//   lol_pulse     one-cycle pulse on loss of lock in RELEASE/RUN
//   retry_cnt     failed attempts in the current sequence
//   state         FSM state code (debug)
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYC     = 500,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int REL_GAP_CYC      = 16,
    parameter int MAX_RETRY        = 3,
    parameter int RW               = 2
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          pll_lock,
    input  logic          force_relock,
    output logic          pll_reset,
    output logic          clk_en,
    output logic          rst0_n,
    output logic          rst1_n,
    output logic          ready,
    output logic          fail,
    output logic          lol_pulse,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
);

    // RELEASE spans two gaps on one running count, so its span joins the maximum.
    localparam int MAX_A = (RST_HOLD_CYC > LOCK_TIMEOUT_CYC) ? RST_HOLD_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_B = (LOCK_STABLE_CYC > 2 * REL_GAP_CYC) ? LOCK_STABLE_CYC : 2 * REL_GAP_CYC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HOLD_LAST   = cnt_t'(RST_HOLD_CYC - 1);
    localparam cnt_t WAIT_LAST   = cnt_t'(LOCK_TIMEOUT_CYC - 1);
    localparam cnt_t STABLE_LAST = cnt_t'(LOCK_STABLE_CYC - 1);
    localparam cnt_t GAP1_LAST   = cnt_t'(REL_GAP_CYC - 1);
    localparam cnt_t GAP2_LAST   = cnt_t'(2 * REL_GAP_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t        state_q, state_nx;
    cnt_t          cnt_q, cnt_nx;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic [RW-1:0] retry_nx;
    logic          pll_reset_nx, clk_en_nx, rst0_n_nx, rst1_n_nx, ready_nx, fail_nx, lol_nx;
    logic          attempt_fail, lock_loss;

    assign lock_s = sync_q[1];
    assign state  = state_q;

    always_comb begin
        state_nx     = state_q;
        cnt_nx       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;   // saturate, never wrap
        retry_nx     = retry_cnt;
        pll_reset_nx = pll_reset;
        clk_en_nx    = clk_en;
        rst0_n_nx    = rst0_n;
        rst1_n_nx    = rst1_n;
        ready_nx     = ready;
        fail_nx      = fail;
        lol_nx       = 1'b0;
        attempt_fail = 1'b0;
        lock_loss    = 1'b0;

        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_nx     = S_WAIT;
                    cnt_nx       = '0;
                    pll_reset_nx = 1'b0;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_nx = S_STABLE;
                    cnt_nx   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    attempt_fail = 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nx  = S_RELEASE;
                    cnt_nx    = '0;
                    clk_en_nx = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!lock_s) begin
                    lock_loss = 1'b1;
                end else if (cnt_q == GAP1_LAST) begin
                    rst0_n_nx = 1'b1;
                end else if (cnt_q == GAP2_LAST) begin
                    state_nx  = S_RUN;
                    cnt_nx    = '0;
                    rst1_n_nx = 1'b1;
                    ready_nx  = 1'b1;
                    retry_nx  = '0;
                end
            end
            S_RUN: begin
                if (!lock_s) lock_loss = 1'b1;
            end
            S_FAIL: begin
                fail_nx = 1'b1;
            end
            default: begin
                state_nx = S_HOLD;
                cnt_nx   = '0;
            end
        endcase

        // A failed attempt re-enters HOLD (or FAIL) with everything back in reset.
        if (attempt_fail) begin
            cnt_nx       = '0;
            pll_reset_nx = 1'b1;
            clk_en_nx    = 1'b0;
            rst0_n_nx    = 1'b0;
            rst1_n_nx    = 1'b0;
            ready_nx     = 1'b0;
            if (retry_cnt == RETRY_MAX) begin
                state_nx = S_FAIL;
                fail_nx  = 1'b1;
            end else begin
                state_nx = S_HOLD;
                retry_nx = retry_cnt + 1'b1;
            end
        end

        // Lock loss after release starts a fresh sequence rather than counting a retry.
        if (lock_loss) begin
            state_nx     = S_HOLD;
            cnt_nx       = '0;
            retry_nx     = '0;
            pll_reset_nx = 1'b1;
            clk_en_nx    = 1'b0;
            rst0_n_nx    = 1'b0;
            rst1_n_nx    = 1'b0;
            ready_nx     = 1'b0;
            lol_nx       = 1'b1;
        end

        // force_relock wins over every other decision on the same edge.
        if (force_relock) begin
            state_nx     = S_HOLD;
            cnt_nx       = '0;
            retry_nx     = '0;
            pll_reset_nx = 1'b1;
            clk_en_nx    = 1'b0;
            rst0_n_nx    = 1'b0;
            rst1_n_nx    = 1'b0;
            ready_nx     = 1'b0;
            fail_nx      = 1'b0;
            lol_nx       = 1'b0;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            retry_cnt <= '0;
            pll_reset <= 1'b1;
            clk_en    <= 1'b0;
            rst0_n    <= 1'b0;
            rst1_n    <= 1'b0;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lol_pulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_lock};
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            retry_cnt <= retry_nx;
            pll_reset <= pll_reset_nx;
            clk_en    <= clk_en_nx;
            rst0_n    <= rst0_n_nx;
            rst1_n    <= rst1_n_nx;
            ready     <= ready_nx;
            fail      <= fail_nx;
            lol_pulse <= lol_nx;
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with params 8/64/16/4/2.
module tb_pll_lock_sequencer;

    logic       clkin = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_reset, clk_en, rst0_n, rst1_n, ready, fail, lol_pulse;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int nvec = 0;
    int nerr = 0;

    always #5 clkin = ~clkin;

    pll_lock_sequencer #(
        .RST_HOLD_CYC(8), .LOCK_TIMEOUT_CYC(64), .LOCK_STABLE_CYC(16),
        .REL_GAP_CYC(4), .MAX_RETRY(2), .RW(2)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .force_relock(force_relock),
        .pll_reset(pll_reset), .clk_en(clk_en), .rst0_n(rst0_n), .rst1_n(rst1_n),
        .ready(ready), .fail(fail), .lol_pulse(lol_pulse), .retry_cnt(retry_cnt),
        .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, ".clk_en"},    32'(clk_en),    32'd0);
        chk({tag, ".rst0_n"},    32'(rst0_n),    32'd0);
        chk({tag, ".rst1_n"},    32'(rst1_n),    32'd0);
        chk({tag, ".ready"},     32'(ready),     32'd0);
        chk({tag, ".fail"},      32'(fail),      32'd0);
        chk({tag, ".lol"},       32'(lol_pulse), 32'd0);
        chk({tag, ".retry"},     32'(retry_cnt), 32'd0);
        chk({tag, ".state"},     32'(state),     32'd0);
    endtask

    // Release lands 1 time unit after a posedge, so the next posedge is edge 1.
    task automatic restart();
        rst_n        = 1'b0;
        pll_lock     = 1'b0;
        force_relock = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #2 chk_reset_outs("por");
        tick(2);
        rst_n = 1'b1;

        // HOLD lasts 8 cycles.
        tick(7);
        chk("hold7.state", 32'(state), 32'd0);
        chk("hold7.pll_reset", 32'(pll_reset), 32'd1);
        tick(1);
        chk("wait.state", 32'(state), 32'd1);
        chk("wait.pll_reset", 32'(pll_reset), 32'd0);

        // Nominal: lock 10 cycles into WAIT, seen 3 edges later.
        tick(10);
        pll_lock = 1'b1;
        tick(2);
        chk("nom.sync2", 32'(state), 32'd1);
        tick(1);
        chk("nom.stable", 32'(state), 32'd2);
        tick(15);
        chk("nom.st15.clk_en", 32'(clk_en), 32'd0);
        tick(1);
        chk("nom.rel.clk_en", 32'(clk_en), 32'd1);
        chk("nom.rel.state", 32'(state), 32'd3);
        chk("nom.rel.rst0_n", 32'(rst0_n), 32'd0);
        tick(3);
        chk("nom.rel3.rst0_n", 32'(rst0_n), 32'd0);
        tick(1);
        chk("nom.rel4.rst0_n", 32'(rst0_n), 32'd1);
        chk("nom.rel4.rst1_n", 32'(rst1_n), 32'd0);
        tick(3);
        chk("nom.rel7.rst1_n", 32'(rst1_n), 32'd0);
        chk("nom.rel7.ready", 32'(ready), 32'd0);
        tick(1);
        chk("nom.run.rst1_n", 32'(rst1_n), 32'd1);
        chk("nom.run.ready", 32'(ready), 32'd1);
        chk("nom.run.state", 32'(state), 32'd4);
        chk("nom.run.retry", 32'(retry_cnt), 32'd0);
        chk("nom.run.pll_reset", 32'(pll_reset), 32'd0);

        // Lock drop in RUN.
        pll_lock = 1'b0;
        tick(2);
        chk("lol.pre.ready", 32'(ready), 32'd1);
        tick(1);
        chk("lol.state", 32'(state), 32'd0);
        chk("lol.clk_en", 32'(clk_en), 32'd0);
        chk("lol.rst0_n", 32'(rst0_n), 32'd0);
        chk("lol.rst1_n", 32'(rst1_n), 32'd0);
        chk("lol.ready", 32'(ready), 32'd0);
        chk("lol.pulse", 32'(lol_pulse), 32'd1);
        chk("lol.retry", 32'(retry_cnt), 32'd0);
        chk("lol.pll_reset", 32'(pll_reset), 32'd1);
        tick(1);
        chk("lol.pulse_end", 32'(lol_pulse), 32'd0);
        tick(7);
        chk("lol.rep.wait", 32'(state), 32'd1);
        pll_lock = 1'b1;
        tick(3);
        chk("lol.rep.stable", 32'(state), 32'd2);
        tick(16);
        chk("lol.rep.release", 32'(state), 32'd3);
        tick(8);
        chk("lol.rep.run", 32'(state), 32'd4);
        chk("lol.rep.ready", 32'(ready), 32'd1);

        // force_relock on the same edge as the second WAIT timeout.
        restart();
        tick(72);
        chk("frc.t72.retry", 32'(retry_cnt), 32'd1);
        chk("frc.t72.state", 32'(state), 32'd0);
        tick(71);
        chk("frc.t143.state", 32'(state), 32'd1);
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("frc.state", 32'(state), 32'd0);
        chk("frc.retry", 32'(retry_cnt), 32'd0);
        chk("frc.fail", 32'(fail), 32'd0);

        // One-cycle lock glitch at STABLE cycle 10.
        restart();
        tick(8);
        chk("gl.wait", 32'(state), 32'd1);
        tick(10);
        pll_lock = 1'b1;
        tick(3);
        chk("gl.stable", 32'(state), 32'd2);
        tick(10);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        tick(1);
        chk("gl.pre.state", 32'(state), 32'd2);
        tick(1);
        chk("gl.state", 32'(state), 32'd0);
        chk("gl.retry", 32'(retry_cnt), 32'd1);
        chk("gl.clk_en", 32'(clk_en), 32'd0);
        chk("gl.pll_reset", 32'(pll_reset), 32'd1);

        // Never lock: three 72-cycle attempts, then FAIL.
        restart();
        tick(72);
        chk("nl.a1.retry", 32'(retry_cnt), 32'd1);
        tick(72);
        chk("nl.a2.retry", 32'(retry_cnt), 32'd2);
        tick(71);
        chk("nl.215.fail", 32'(fail), 32'd0);
        chk("nl.215.state", 32'(state), 32'd1);
        tick(1);
        chk("nl.216.fail", 32'(fail), 32'd1);
        chk("nl.216.state", 32'(state), 32'd5);
        chk("nl.216.pll_reset", 32'(pll_reset), 32'd1);
        chk("nl.216.clk_en", 32'(clk_en), 32'd0);
        chk("nl.216.retry", 32'(retry_cnt), 32'd2);
        tick(5);
        chk("nl.sticky.fail", 32'(fail), 32'd1);
        chk("nl.sticky.state", 32'(state), 32'd5);

        // Recovery from FAIL via force_relock, then a full sequence.
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("rec.fail", 32'(fail), 32'd0);
        chk("rec.retry", 32'(retry_cnt), 32'd0);
        chk("rec.state", 32'(state), 32'd0);
        tick(8);
        chk("rec.wait", 32'(state), 32'd1);
        pll_lock = 1'b1;
        tick(3);
        chk("rec.stable", 32'(state), 32'd2);
        tick(16);
        chk("rec.release", 32'(state), 32'd3);
        tick(8);
        chk("rec.run", 32'(state), 32'd4);
        chk("rec.ready", 32'(ready), 32'd1);

        // force_relock beats lock loss on the same edge: no lol_pulse.
        pll_lock = 1'b0;
        tick(2);
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        chk("frl.state", 32'(state), 32'd0);
        chk("frl.lol", 32'(lol_pulse), 32'd0);
        chk("frl.ready", 32'(ready), 32'd0);
        tick(1);
        chk("frl.lol_next", 32'(lol_pulse), 32'd0);

        // Async reset in the middle of RELEASE after rst0_n has risen.
        restart();
        tick(8);
        pll_lock = 1'b1;
        tick(3);
        tick(16);
        chk("mr.release", 32'(state), 32'd3);
        tick(5);
        chk("mr.rst0_n", 32'(rst0_n), 32'd1);
        chk("mr.rst1_n", 32'(rst1_n), 32'd0);
        rst_n = 1'b0;
        #2 chk_reset_outs("mr");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
